alu_seq: RTL

Handshaked, multi-cycle successor to the combinational ALU: same op encodings and flag semantics, generalised to any `DWIDTH`, plus an iterative signed multiplier and an optional iterative signed divider. It sits between the decode/issue stage and writeback. Operands are captured on a valid/ready handshake, and results are held in output registers until the consumer accepts them.

---
 rtl/alu_seq.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// alu_seq: handshaked multi-cycle ALU with iterative signed multiplier; define ALU_SEQ_DIV_EN to add the iterative signed divider
module alu_seq #(
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op,
    input  logic [DWIDTH-1:0] rs1,
    input  logic [DWIDTH-1:0] rs2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] rd,
    output logic              zero,
    output logic              overflow
);
    localparam int CW = $clog2(DWIDTH + 1);
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_DIV = 4'b1001;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t              state;
    logic [3:0]          op_r;
    logic [DWIDTH-1:0]   a, b, mp, res, sum, dif;
    logic [2*DWIDTH-1:0] mc, acc, prod;
    logic [CW-1:0]       cnt;
    logic                neg, res_ovf, res_vld, is_div, iter;
    function automatic logic [DWIDTH-1:0] mag(input logic [DWIDTH-1:0] x);
        return x[DWIDTH-1] ? -x : x;
    endfunction
`ifdef ALU_SEQ_DIV_EN
    logic [DWIDTH-1:0] rem, rem_nxt;
    logic [DWIDTH:0]   rsh;
    logic              ge;
    assign is_div = op == OP_DIV;
    // restoring-division step: shift next dividend bit into the remainder and subtract if it fits
    always_comb begin
        rsh     = {rem, mp[DWIDTH-1]};
        ge      = rsh >= {1'b0, mc[DWIDTH-1:0]};
        rem_nxt = ge ? DWIDTH'(rsh - {1'b0, mc[DWIDTH-1:0]}) : rsh[DWIDTH-1:0];
    end
`else
    assign is_div = 1'b0;
`endif
    assign iter = op == OP_MUL || is_div;
    // final result and flags from the latched operands and the iterative datapath
    always_comb begin
        sum     = a + b;
        dif     = a - b;
        prod    = neg ? -acc : acc;
        res     = '0;
        res_ovf = 1'b0;
        res_vld = 1'b1;
        case (op_r)
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_ADD: begin
                res     = sum;
                res_ovf = a[DWIDTH-1] == b[DWIDTH-1] && sum[DWIDTH-1] != a[DWIDTH-1];
            end
            OP_SUB: begin
                res     = dif;
                res_ovf = a[DWIDTH-1] != b[DWIDTH-1] && dif[DWIDTH-1] != a[DWIDTH-1];
            end
            OP_SLT: res = {{(DWIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            OP_NOR: res = ~(a | b);
            OP_MUL: begin
                res     = prod[DWIDTH-1:0];
                res_ovf = !(&prod[2*DWIDTH-1:DWIDTH-1] || !(|prod[2*DWIDTH-1:DWIDTH-1]));
            end
`ifdef ALU_SEQ_DIV_EN
            OP_DIV: begin
                res_ovf = b == '0 || (a == {1'b1, {(DWIDTH-1){1'b0}}} && b == '1);
                res     = b == '0 ? '1 : res_ovf ? a : neg ? -mp : mp;
            end
`endif
            default: res_vld = 1'b0;
        endcase
    end
    // control FSM, iteration datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            rd        <= '0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            op_r      <= '0;
            a         <= '0;
            b         <= '0;
            mc        <= '0;
            mp        <= '0;
            acc       <= '0;
            neg       <= 1'b0;
            cnt       <= '0;
`ifdef ALU_SEQ_DIV_EN
            rem       <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    op_r     <= op;
                    a        <= rs1;
                    b        <= rs2;
                    neg      <= rs1[DWIDTH-1] ^ rs2[DWIDTH-1];
                    acc      <= '0;
                    mc       <= {{DWIDTH{1'b0}}, is_div ? mag(rs2) : mag(rs1)};
                    mp       <= is_div ? mag(rs1) : mag(rs2);
                    cnt      <= iter ? '0 : CW'(DWIDTH);
                    in_ready <= 1'b0;
                    state    <= BUSY;
`ifdef ALU_SEQ_DIV_EN
                    rem      <= '0;
`endif
                end
                BUSY: if (cnt == CW'(DWIDTH)) begin
                    rd        <= res;
                    overflow  <= res_ovf;
                    zero      <= res_vld && !res_ovf && res == '0;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end else begin
                    cnt <= cnt + 1'b1;
`ifdef ALU_SEQ_DIV_EN
                    if (op_r == OP_DIV) begin
                        rem <= rem_nxt;
                        mp  <= {mp[DWIDTH-2:0], ge};
                    end else
`endif
                    begin
                        acc <= acc + (mp[0] ? mc : '0);
                        mc  <= mc << 1;
                        mp  <= mp >> 1;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
